mem_arbiter: RTL and testbench

- Arbiter and sequencer for the single-port unified instruction/data memory of the 16-bit CPU.
- Two requesters share the memory: fetch (I-side, PC address) and load/store (D-side, driven by the decoded LW/SW opcodes 1000/1001).
- The memory has fixed latency. The block grants one requester at a time, times the access, captures read data and returns a one-cycle done pulse.
- It supports fetch flush on a taken branch and fetch gating on HLT.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arb_timer.sv | 25 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and decode constants for the unified memory arbiter.
// Opcodes are kept here so request generation upstream matches decode.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle for the arbiter.
// slave is the arbiter view; master is the CPU/memory view.
interface mem_arbiter_if;

   logic        i_req;
   logic [15:0] i_addr;
   logic        i_flush;
   logic [15:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_done;
   logic        halt;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   modport slave (
      input  i_req, i_addr, i_flush,
      input  d_req, d_wr, d_addr, d_wdata,
      input  halt, mem_rdata,
      output i_rdata, i_done, d_rdata, d_done,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output i_req, i_addr, i_flush,
      output d_req, d_wr, d_addr, d_wdata,
      output halt, mem_rdata,
      input  i_rdata, i_done, d_rdata, d_done,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  busy
   );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable 4-bit down-counter with zero flag for access latency.
module mem_arb_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter and sequencer for the single-port memory.
// D has priority; a starvation counter forces an I grant periodically.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY  = 4,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state;
   state_t     state_nx;
   owner_t     owner;
   logic       own_wr;
   logic       kill;
   logic [3:0] starve_cnt;
   logic       grant_i;
   logic       grant_d;
   logic       grant;
   logic       i_ok;
   logic       cnt_zero;
   logic       last;

   assign i_ok  = bus.i_req && !bus.halt && !bus.i_flush;
   assign grant = grant_i || grant_d;
   assign last  = (state == BUSY) && cnt_zero;

   always_comb begin
      state_nx = state;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_ok && (!bus.d_req || starve_cnt == STARVE_MAX)) begin
               grant_i = 1'b1;
            end else if (bus.d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_nx = BUSY;
            end
         end
         BUSY:    if (cnt_zero) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   mem_arb_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (grant),
      .load_val (LAT_LOAD),
      .dec      (state == BUSY),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= OWN_I;
         own_wr        <= 1'b0;
         kill          <= 1'b0;
         starve_cnt    <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.i_rdata   <= '0;
         bus.d_rdata   <= '0;
      end else begin
         state      <= state_nx;
         bus.mem_en <= grant;
         bus.mem_wr <= grant_d && bus.d_wr;
         if (grant_d) begin
            owner         <= OWN_D;
            own_wr        <= bus.d_wr;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            if (!bus.i_req) begin
               starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
         if (grant_i) begin
            owner         <= OWN_I;
            own_wr        <= 1'b0;
            bus.mem_addr  <= bus.i_addr;
            bus.mem_wdata <= '0;
            starve_cnt    <= '0;
         end
         // a flush on the final BUSY cycle must also suppress the capture
         if (state == BUSY && owner == OWN_I && bus.i_flush) begin
            kill <= 1'b1;
         end else if (state == DONE) begin
            kill <= 1'b0;
         end
         if (last && owner == OWN_D && !own_wr) begin
            bus.d_rdata <= bus.mem_rdata;
         end
         if (last && owner == OWN_I && !kill && !bus.i_flush) begin
            bus.i_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.i_done = (state == DONE) && (owner == OWN_I) && !kill;
   assign bus.d_done = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle sequences.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if bif ();
   mem_arbiter_if bif1 ();

   mem_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bif1.slave)
   );

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hA123 : (a ^ 16'h5A5A);
   endfunction

   // memory models: data valid LAT-1 cycles after the mem_en cycle
   logic [2:0] en_pipe = '0;
   always @(posedge clk) en_pipe <= {en_pipe[1:0], bif.mem_en};
   assign bif.mem_rdata  = en_pipe[2] ? mem_val(bif.mem_addr) : 16'hDEAD;
   assign bif1.mem_rdata = bif1.mem_en ? mem_val(bif1.mem_addr) : 16'hDEAD;

   int          en_cyc[$];
   logic [15:0] en_addr[$];
   logic        en_wr[$];
   logic [15:0] en_wdata[$];
   int          idone_cyc[$];
   int          ddone_cyc[$];

   always @(negedge clk) begin
      if (bif.mem_en) begin
         en_cyc.push_back(cyc);
         en_addr.push_back(bif.mem_addr);
         en_wr.push_back(bif.mem_wr);
         en_wdata.push_back(bif.mem_wdata);
      end
      if (bif.i_done) idone_cyc.push_back(cyc);
      if (bif.d_done) ddone_cyc.push_back(cyc);
   end

   logic pd_req = 1'b0;
   logic pi_req = 1'b0;
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(pd_req && !bif.d_req && !bif.d_done))
            else $error("protocol: d_req dropped before d_done");
         assert (!(pi_req && !bif.i_req && !bif.i_done && !bif.i_flush))
            else $error("protocol: i_req dropped before i_done");
      end
      pd_req <= bif.d_req;
      pi_req <= bif.i_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      en_cyc.delete();
      en_addr.delete();
      en_wr.delete();
      en_wdata.delete();
      idone_cyc.delete();
      ddone_cyc.delete();
   endtask

   // sel: 0 main I, 1 main D, 2 lat-1 I, 3 lat-1 D
   task automatic wait_done(input int sel, input int limit, output int at);
      at = -1;
      for (int k = 0; k < limit && at < 0; k++) begin
         tick();
         case (sel)
            0: if (bif.i_done) at = cyc;
            1: if (bif.d_done) at = cyc;
            2: if (bif1.i_done) at = cyc;
            default: if (bif1.d_done) at = cyc;
         endcase
      end
      if (at < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout sel=%0d: got none want done", sel);
      end
   endtask

   typedef struct {
      bit          isd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vt[5];

   initial begin
      int t0;
      int t1;
      int at;
      int ai;
      int ad;
      bit busy_seen;

      vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA123};
      vt[1] = '{1'b1, 1'b0, 16'h0234, 16'h0000, 16'h586E};
      vt[2] = '{1'b1, 1'b1, 16'h0200, 16'h55AA, 16'h586E};
      vt[3] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'h5A18};
      vt[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h5AA5};

      {bif.i_req, bif.i_flush, bif.d_req, bif.d_wr, bif.halt} = '0;
      {bif.i_addr, bif.d_addr, bif.d_wdata} = '0;
      {bif1.i_req, bif1.i_flush, bif1.d_req, bif1.d_wr, bif1.halt} = '0;
      {bif1.i_addr, bif1.d_addr, bif1.d_wdata} = '0;

      repeat (3) tick();
      chk("rst busy", 32'(bif.busy), 0);
      chk("rst mem_en", 32'(bif.mem_en), 0);
      chk("rst mem_addr", 32'(bif.mem_addr), 0);
      chk("rst i_done", 32'(bif.i_done), 0);
      chk("rst d_done", 32'(bif.d_done), 0);
      chk("rst i_rdata", 32'(bif.i_rdata), 0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 5; k++) begin
         clr();
         t0 = cyc;
         if (vt[k].isd) begin
            bif.d_req   = 1'b1;
            bif.d_wr    = vt[k].wr;
            bif.d_addr  = vt[k].addr;
            bif.d_wdata = vt[k].wdata;
         end else begin
            bif.i_req  = 1'b1;
            bif.i_addr = vt[k].addr;
         end
         wait_done(vt[k].isd ? 1 : 0, 20, at);
         chk($sformatf("v%0d rdata", k),
             32'(vt[k].isd ? bif.d_rdata : bif.i_rdata), 32'(vt[k].exp_rd));
         bif.d_req = 1'b0;
         bif.i_req = 1'b0;
         chk($sformatf("v%0d latency", k), 32'(at - t0), 5);
         chk($sformatf("v%0d en count", k), 32'(en_cyc.size()), 1);
         chk($sformatf("v%0d en cycle", k), 32'(en_cyc[0] - t0), 1);
         chk($sformatf("v%0d mem_addr", k), 32'(en_addr[0]), 32'(vt[k].addr));
         chk($sformatf("v%0d mem_wr", k), 32'(en_wr[0]),
             32'(vt[k].isd && vt[k].wr));
         if (vt[k].isd && vt[k].wr)
            chk($sformatf("v%0d mem_wdata", k), 32'(en_wdata[0]),
                32'(vt[k].wdata));
         tick();
         chk($sformatf("v%0d busy after", k), 32'(bif.busy), 0);
      end

      // simultaneous store and fetch: D first, then I
      clr();
      t0 = cyc;
      bif.d_req = 1'b1; bif.d_wr = 1'b1;
      bif.d_addr = 16'h0200; bif.d_wdata = 16'h55AA;
      bif.i_req = 1'b1; bif.i_addr = 16'h0010;
      wait_done(1, 20, ad);
      bif.d_req = 1'b0; bif.d_wr = 1'b0;
      wait_done(0, 20, ai);
      bif.i_req = 1'b0;
      chk("t2 d_done lat", 32'(ad - t0), 5);
      chk("t2 first wr", 32'(en_wr[0]), 1);
      chk("t2 first addr", 32'(en_addr[0]), 32'h0200);
      chk("t2 first wdata", 32'(en_wdata[0]), 32'h55AA);
      chk("t2 I en after d_done", 32'(en_cyc[1] - ad), 2);
      chk("t2 I addr", 32'(en_addr[1]), 32'h0010);
      chk("t2 i_done lat", 32'(ai - t0), 11);
      tick();

      // starvation: D,D,D,D,I,D
      clr();
      t0 = cyc;
      bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_addr = 16'h0300;
      bif.i_req = 1'b1; bif.i_addr = 16'h0010;
      wait_done(0, 35, ai);
      bif.i_req = 1'b0;
      chk("t3 i_done time", 32'(ai - t0), 29);
      chk("t3 grant count", 32'(en_cyc.size()), 5);
      chk("t3 4th grant D", 32'(en_addr[3]), 32'h0300);
      chk("t3 5th grant I", 32'(en_addr[4]), 32'h0010);
      wait_done(1, 20, ad);
      bif.d_req = 1'b0;
      chk("t3 next D done", 32'(ad - t0), 35);
      chk("t3 d_rdata", 32'(bif.d_rdata), 32'h595A);
      tick();

      // flush during an I access
      clr();
      t0 = cyc;
      bif.i_req = 1'b1; bif.i_addr = 16'h0042;
      tick();
      tick();
      bif.i_flush = 1'b1; bif.i_addr = 16'h0044;
      tick();
      bif.i_flush = 1'b0;
      tick();
      tick();
      chk("t4 killed i_done", 32'(bif.i_done), 0);
      chk("t4 i_rdata held", 32'(bif.i_rdata), 32'hA123);
      chk("t4 busy in done", 32'(bif.busy), 1);
      wait_done(0, 20, ai);
      bif.i_req = 1'b0;
      chk("t4 refetch lat", 32'(ai - t0), 11);
      chk("t4 refetch data", 32'(bif.i_rdata), 32'h5A1E);
      chk("t4 killed addr", 32'(en_addr[0]), 32'h0042);
      chk("t4 new addr", 32'(en_addr[1]), 32'h0044);
      tick();
      chk("t4 i_done count", 32'(idone_cyc.size()), 1);

      // halt blocks fetch, D still served
      clr();
      bif.halt = 1'b1;
      bif.i_req = 1'b1; bif.i_addr = 16'h0010;
      busy_seen = 1'b0;
      repeat (20) begin
         tick();
         if (bif.busy) busy_seen = 1'b1;
      end
      chk("t5 no mem_en", 32'(en_cyc.size()), 0);
      chk("t5 no busy", 32'(busy_seen), 0);
      t1 = cyc;
      bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_addr = 16'h0234;
      wait_done(1, 20, ad);
      bif.d_req = 1'b0;
      bif.halt = 1'b0;
      chk("t5 d lat", 32'(ad - t1), 5);
      chk("t5 d_rdata", 32'(bif.d_rdata), 32'h586E);
      wait_done(0, 20, ai);
      bif.i_req = 1'b0;
      chk("t5 I after halt", 32'(ai - ad), 6);
      tick();

      // reset mid D read, then rerun
      clr();
      t0 = cyc;
      bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_addr = 16'h0300;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t6 busy", 32'(bif.busy), 0);
      chk("t6 mem_en", 32'(bif.mem_en), 0);
      chk("t6 mem_wr", 32'(bif.mem_wr), 0);
      chk("t6 mem_addr", 32'(bif.mem_addr), 0);
      chk("t6 mem_wdata", 32'(bif.mem_wdata), 0);
      chk("t6 i_rdata", 32'(bif.i_rdata), 0);
      chk("t6 d_rdata", 32'(bif.d_rdata), 0);
      chk("t6 d_done", 32'(bif.d_done), 0);
      rst = 1'b0;
      wait_done(1, 20, ad);
      chk("t6 no early done", 32'(ddone_cyc.size()), 0);
      bif.d_req = 1'b0;
      chk("t6 rerun lat", 32'(ad - t0), 9);
      chk("t6 rerun data", 32'(bif.d_rdata), 32'h595A);
      tick();

      // MEM_LATENCY = 1 instance
      t0 = cyc;
      bif1.d_req = 1'b1; bif1.d_addr = 16'h0234;
      wait_done(3, 10, ad);
      bif1.d_req = 1'b0;
      chk("l1 d lat", 32'(ad - t0), 2);
      chk("l1 d_rdata", 32'(bif1.d_rdata), 32'h586E);
      tick();
      t0 = cyc;
      bif1.i_req = 1'b1; bif1.i_addr = 16'h0010;
      wait_done(2, 10, ai);
      bif1.i_req = 1'b0;
      chk("l1 i lat", 32'(ai - t0), 2);
      chk("l1 i_rdata", 32'(bif1.i_rdata), 32'hA123);
      tick();
      chk("l1 busy after", 32'(bif1.busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
